// File: rtl/hb_mac_scheduler.sv
// Shared-MAC sequencer for one decimation stage: walks every (channel, tap) op
// per frame, flags accumulator loads and delays tap-last events into writebacks.
module hb_mac_scheduler #(
  parameter int NCH     = 20,
  parameter int NTAP    = 8,
  parameter int CHW     = 5,
  parameter int TAPW    = 3,
  parameter int MAC_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            clr_err,
  output logic            busy,
  output logic            mac_vld,
  output logic            mac_first,
  output logic [CHW-1:0]  ch_idx,
  output logic [TAPW-1:0] tap_idx,
  output logic            out_wr,
  output logic [CHW-1:0]  out_ch,
  output logic            done,
  output logic            overrun
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [CHW-1:0]  CH_LAST   = CHW'(NCH - 1);
  localparam logic [TAPW-1:0] TAP_LAST  = TAPW'(NTAP - 1);
  localparam logic [DW-1:0]   DRAIN_END = DW'(MAC_LAT - 1);

  state_t         state;
  logic [DW-1:0]  drain_cnt;
  logic           wb_evt;
  logic           wb_vld [MAC_LAT];
  logic [CHW-1:0] wb_ch  [MAC_LAT];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      busy      <= 1'b0;
      mac_vld   <= 1'b0;
      mac_first <= 1'b0;
      ch_idx    <= '0;
      tap_idx   <= '0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done <= 1'b0;
      // An offending start beats a simultaneous clear.
      if (start && busy)
        overrun <= 1'b1;
      else if (clr_err)
        overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            mac_vld   <= 1'b1;
            mac_first <= 1'b1;
            ch_idx    <= '0;
            tap_idx   <= '0;
          end
        end
        RUN: begin
          if (tap_idx == TAP_LAST && ch_idx == CH_LAST) begin
            state     <= DRAIN;
            mac_vld   <= 1'b0;
            mac_first <= 1'b0;
            ch_idx    <= '0;
            tap_idx   <= '0;
            drain_cnt <= '0;
          end else if (tap_idx == TAP_LAST) begin
            tap_idx   <= '0;
            ch_idx    <= ch_idx + CHW'(1);
            mac_first <= 1'b1;
          end else begin
            tap_idx   <= tap_idx + TAPW'(1);
            mac_first <= 1'b0;
          end
        end
        DRAIN: begin
          // Hold until the last channel's result has left the MAC.
          if (drain_cnt == DRAIN_END) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wb_evt = mac_vld && (tap_idx == TAP_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < MAC_LAT; gi++) begin : g_wb
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (!rst) begin
            wb_vld[0] <= 1'b0;
            wb_ch[0]  <= '0;
          end else begin
            wb_vld[0] <= wb_evt;
            wb_ch[0]  <= wb_evt ? ch_idx : '0;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (!rst) begin
            wb_vld[gi] <= 1'b0;
            wb_ch[gi]  <= '0;
          end else begin
            wb_vld[gi] <= wb_vld[gi-1];
            wb_ch[gi]  <= wb_ch[gi-1];
          end
        end
      end
    end
  endgenerate

  assign out_wr = wb_vld[MAC_LAT-1];
  assign out_ch = wb_ch[MAC_LAT-1];

endmodule
